// File: rtl/sm_intc_pkg.sv
// ============================================================================
// Module   : sm_intc_pkg
// Brief    : Register offsets, ID width and CLAIM layout for sm_intc.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sm_intc_pkg;

    localparam int SM_INTC_ID_W            = 5;
    localparam int SM_INTC_CLAIM_VALID_BIT = 31;

    localparam logic [1:0] SM_INTC_REG_PENDING = 2'd0;
    localparam logic [1:0] SM_INTC_REG_ENABLE  = 2'd1;
    localparam logic [1:0] SM_INTC_REG_EDGE    = 2'd2;
    localparam logic [1:0] SM_INTC_REG_CLAIM   = 2'd3;

    typedef logic [SM_INTC_ID_W-1:0] irqId_t;

endpackage

`default_nettype wire

// File: rtl/sm_intc_prio.sv
// ============================================================================
// Module   : sm_intc_prio
// Brief    : Combinational lowest-index-first priority encoder -> {valid, id}.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sm_intc_prio
    import sm_intc_pkg::*;
#(
    parameter int IRQ_NUM = 8
) (
    input  logic [IRQ_NUM-1:0] req,
    output logic               valid,
    output irqId_t             id
);

    // Scanning downwards lets the lowest set index be the last assignment.
    always_comb begin
        valid = 1'b0;
        id    = '0;
        for (int i = IRQ_NUM - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                id    = irqId_t'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/sm_intc.sv
// ============================================================================
// Module   : sm_intc
// Brief    : External interrupt controller with edge/level sources, enable
//            mask and claim/complete. SM_INTC_SYNC_EN adds 2-flop input sync.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sm_intc
    import sm_intc_pkg::*;
#(
    parameter int IRQ_NUM = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [IRQ_NUM-1:0] irq_src,
    input  logic               bus_sel,
    input  logic [3:0]         bus_addr,
    input  logic               bus_we,
    input  logic [31:0]        bus_wd,
    output logic [31:0]        bus_rd,
    output logic               irq_out
);

    logic [IRQ_NUM-1:0] r_pending;
    logic [IRQ_NUM-1:0] r_enable;
    logic [IRQ_NUM-1:0] r_edge;
    logic [IRQ_NUM-1:0] r_prev;
    logic               r_irqOut;

    logic [IRQ_NUM-1:0] w_sample;
    logic [IRQ_NUM-1:0] w_rise;
    logic [IRQ_NUM-1:0] w_swClr;
    logic [IRQ_NUM-1:0] w_modeChg;
    logic [IRQ_NUM-1:0] w_pendingNxt;
    logic [IRQ_NUM-1:0] w_active;
    logic               w_wrEn;
    logic               w_wrPending;
    logic               w_wrEnable;
    logic               w_wrEdge;
    logic               w_wrClaim;
    logic               w_claimValid;
    irqId_t             w_claimId;
    logic               w_unused;

`ifdef SM_INTC_SYNC_EN
    logic [IRQ_NUM-1:0] r_sync1;
    logic [IRQ_NUM-1:0] r_sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= irq_src;
            r_sync2 <= r_sync1;
        end
    end

    assign w_sample = r_sync2;
`else
    assign w_sample = irq_src;
`endif

    assign w_wrEn      = bus_sel & bus_we;
    assign w_wrPending = w_wrEn && (bus_addr[3:2] == SM_INTC_REG_PENDING);
    assign w_wrEnable  = w_wrEn && (bus_addr[3:2] == SM_INTC_REG_ENABLE);
    assign w_wrEdge    = w_wrEn && (bus_addr[3:2] == SM_INTC_REG_EDGE);
    assign w_wrClaim   = w_wrEn && (bus_addr[3:2] == SM_INTC_REG_CLAIM);

    assign w_rise    = w_sample & ~r_prev;
    assign w_modeChg = w_wrEdge ? (bus_wd[IRQ_NUM-1:0] ^ r_edge) : '0;

    // Out-of-range claim IDs simply match no source.
    always_comb begin
        w_swClr = w_wrPending ? bus_wd[IRQ_NUM-1:0] : '0;
        for (int i = 0; i < IRQ_NUM; i++) begin
            if (w_wrClaim && (bus_wd[SM_INTC_ID_W-1:0] == irqId_t'(i))) begin
                w_swClr[i] = 1'b1;
            end
        end
    end

    // Edge: set beats clear; level: follow the input; mode change clears.
    assign w_pendingNxt = ((r_edge & ((r_pending & ~w_swClr) | w_rise))
                          | (~r_edge & w_sample)) & ~w_modeChg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
            r_enable  <= '0;
            r_edge    <= '0;
            r_prev    <= '0;
            r_irqOut  <= 1'b0;
        end else begin
            r_prev    <= w_sample;
            r_pending <= w_pendingNxt;
            r_irqOut  <= |(r_pending & r_enable);
            if (w_wrEnable) begin
                r_enable <= bus_wd[IRQ_NUM-1:0];
            end
            if (w_wrEdge) begin
                r_edge <= bus_wd[IRQ_NUM-1:0];
            end
        end
    end

    assign w_active = r_pending & r_enable;

    sm_intc_prio #(
        .IRQ_NUM (IRQ_NUM)
    ) u_prio (
        .req   (w_active),
        .valid (w_claimValid),
        .id    (w_claimId)
    );

    always_comb begin
        bus_rd = '0;
        case (bus_addr[3:2])
            SM_INTC_REG_PENDING: bus_rd[IRQ_NUM-1:0] = r_pending;
            SM_INTC_REG_ENABLE:  bus_rd[IRQ_NUM-1:0] = r_enable;
            SM_INTC_REG_EDGE:    bus_rd[IRQ_NUM-1:0] = r_edge;
            SM_INTC_REG_CLAIM: begin
                bus_rd[SM_INTC_CLAIM_VALID_BIT] = w_claimValid;
                bus_rd[SM_INTC_ID_W-1:0]        = w_claimId;
            end
            default: bus_rd = '0;
        endcase
    end

    assign irq_out  = r_irqOut;
    assign w_unused = ^{bus_addr[1:0], bus_wd};

endmodule

`default_nettype wire

// File: tb/tb_sm_intc.sv
// ============================================================================
// Module   : tb_sm_intc
// Brief    : Self-checking bench for sm_intc (directed steps + random traffic).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sm_intc;

    localparam int N = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  irq_src;
    logic          bus_sel;
    logic [3:0]    bus_addr;
    logic          bus_we;
    logic [31:0]   bus_wd;
    logic [31:0]   bus_rd;
    logic          irq_out;

    int checks   = 0;
    int failures = 0;

    // Reference state
    bit [N-1:0] mPend, mEn, mEdge, mPrev, mS1, mS2;

    sm_intc #(
        .IRQ_NUM (N)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .irq_src  (irq_src),
        .bus_sel  (bus_sel),
        .bus_addr (bus_addr),
        .bus_we   (bus_we),
        .bus_wd   (bus_wd),
        .bus_rd   (bus_rd),
        .irq_out  (irq_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit [31:0] modelRead(input bit [3:0] a);
        case (a[3:2])
            2'd0: return 32'(mPend);
            2'd1: return 32'(mEn);
            2'd2: return 32'(mEdge);
            default: begin
                for (int i = 0; i < N; i++)
                    if (mPend[i] && mEn[i]) return {1'b1, 26'b0, 5'(i)};
                return 32'h0;
            end
        endcase
    endfunction

    task automatic modelReset();
        mPend = '0; mEn = '0; mEdge = '0; mPrev = '0; mS1 = '0; mS2 = '0;
    endtask

    // One clock: predict from the inputs present before the edge, then compare irq_out.
    task automatic step();
        bit [N-1:0]  s, nPend, src;
        bit          wr, nIrq;
        bit [1:0]    reg_;
        bit [31:0]   wd;
        src  = irq_src;
        wr   = bus_sel && bus_we;
        reg_ = bus_addr[3:2];
        wd   = bus_wd;
`ifdef SM_INTC_SYNC_EN
        s = mS2;
`else
        s = src;
`endif
        nIrq = |(mPend & mEn);
        for (int i = 0; i < N; i++) begin
            if (wr && reg_ == 2'd2 && wd[i] != mEdge[i])
                nPend[i] = 1'b0;
            else if (mEdge[i]) begin
                if (s[i] && !mPrev[i])
                    nPend[i] = 1'b1;
                else if ((wr && reg_ == 2'd0 && wd[i]) || (wr && reg_ == 2'd3 && wd[4:0] == i))
                    nPend[i] = 1'b0;
                else
                    nPend[i] = mPend[i];
            end else
                nPend[i] = s[i];
        end
        @(posedge clk);
        #1;
        mPend = nPend;
        mPrev = s;
        mS2   = mS1;
        mS1   = src;
        if (wr && reg_ == 2'd1) mEn   = wd[N-1:0];
        if (wr && reg_ == 2'd2) mEdge = wd[N-1:0];
        check("irq_out", {31'b0, irq_out}, {31'b0, nIrq});
    endtask

    task automatic checkAll(input string tag);
        logic [3:0] saved;
        saved = bus_addr;
        for (int a = 0; a < 4; a++) begin
            bus_addr = 4'(a << 2);
            #1;
            check($sformatf("%s_reg%0d", tag, a), bus_rd, modelRead(bus_addr));
        end
        bus_addr = saved;
    endtask

    task automatic expectReg(input bit [3:0] a, input string tag, input logic [31:0] val);
        bus_addr = a;
        #1;
        check(tag, bus_rd, val);
    endtask

    task automatic busWrite(input bit [3:0] a, input bit [31:0] d);
        bus_sel = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wd = d;
        step();
        bus_sel = 1'b0; bus_we = 1'b0;
    endtask

    initial begin
        rst = 1'b1; irq_src = '0; bus_sel = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wd = '0;
        modelReset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        for (int a = 0; a < 4; a++) expectReg(4'(a << 2), $sformatf("reset_reg%0d", a), 32'h0);
        check("reset_irq", {31'b0, irq_out}, 32'h0);

        // Edge source 0 through claim
        busWrite(4'h8, 32'h01);
        busWrite(4'h4, 32'h01);
        irq_src[0] = 1'b1; step(); irq_src[0] = 1'b0;
`ifndef SM_INTC_SYNC_EN
        expectReg(4'h0, "edge0_pending", 32'h01);
        step();
        check("edge0_irq", {31'b0, irq_out}, 32'h1);
        expectReg(4'hC, "edge0_claim", 32'h8000_0000);
        busWrite(4'hC, 32'h0);
        step();
        check("edge0_irq_drop", {31'b0, irq_out}, 32'h0);
`else
        repeat (4) step();
        busWrite(4'hC, 32'h0);
        step();
`endif
        checkAll("edge0");

        // Level source 3 ignores software clears
        busWrite(4'h8, 32'h00);
        busWrite(4'h4, 32'h08);
        irq_src[3] = 1'b1;
        repeat (4) step();
        expectReg(4'h0, "level3_pending", 32'h08);
        check("level3_irq", {31'b0, irq_out}, 32'h1);
        busWrite(4'h0, 32'h08);
        expectReg(4'h0, "level3_w1c", 32'h08);
        irq_src[3] = 1'b0;
        repeat (4) step();
        expectReg(4'h0, "level3_drop", 32'h0);
        check("level3_irq_drop", {31'b0, irq_out}, 32'h0);

        // Two edge sources, claimed lowest first
        busWrite(4'h8, 32'hFF);
        busWrite(4'h4, 32'h24);
        irq_src = 8'h24; step(); irq_src = '0;
        repeat (3) step();
        expectReg(4'hC, "claim_first", 32'h8000_0002);
        busWrite(4'hC, 32'h2);
        expectReg(4'hC, "claim_second", 32'h8000_0005);
        busWrite(4'hC, 32'h5);
        expectReg(4'hC, "claim_none", 32'h0);
        step();
        check("claim_irq_drop", {31'b0, irq_out}, 32'h0);

        // Set wins over a simultaneous W1C
        irq_src[1] = 1'b1; step(); irq_src[1] = 1'b0;
        repeat (3) step();
        expectReg(4'h0, "src1_pending", 32'h02);
        irq_src[1] = 1'b1;
        busWrite(4'h0, 32'h02);
        irq_src[1] = 1'b0;
        checkAll("set_vs_clr");
        busWrite(4'h0, 32'h02);
        checkAll("src1_clear");

        // Masked source still latches
        busWrite(4'h4, 32'h00);
        irq_src[4] = 1'b1; step(); irq_src[4] = 1'b0;
        repeat (3) step();
        expectReg(4'h0, "masked_pending", 32'h10);
        check("masked_irq", {31'b0, irq_out}, 32'h0);
        busWrite(4'h4, 32'h10);
        step();
        check("unmask_irq", {31'b0, irq_out}, 32'h1);

        // Asynchronous reset mid-operation
        #2 rst = 1'b1;
        #1;
        for (int a = 0; a < 4; a++) expectReg(4'(a << 2), $sformatf("midrst_reg%0d", a), 32'h0);
        check("midrst_irq", {31'b0, irq_out}, 32'h0);
        modelReset();
        @(negedge clk) rst = 1'b0;
        repeat (3) step();
        checkAll("post_rst");

        // Random traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            irq_src  = irq_src ^ N'($urandom & $urandom & $urandom);
            bus_sel  = ($urandom_range(0, 2) == 0);
            bus_we   = 1'($urandom_range(0, 1));
            bus_addr = 4'($urandom);
            bus_wd   = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 15));
            step();
            bus_sel = 1'b0; bus_we = 1'b0;
            checkAll("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
